tug_referee: RTL and testbench



---
 rtl/tug_pkg.sv | 38 +++
 rtl/tug_timer.sv | 35 +++
 rtl/tug_referee.sv | 175 +++++++++++++++++
 tb/tb_tug_referee.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/tug_pkg.sv
// Shared types and helpers for the tug-of-war referee: round states, winner
// encoding and the half-bar light pattern shown while a round win is displayed.
package tug_pkg;

   typedef enum logic [2:0] {
      StIdle,
      StCountdown,
      StPlay,
      StWin,
      StOver
   } state_e;

   localparam logic [1:0] WIN_NONE  = 2'b00;
   localparam logic [1:0] WIN_LEFT  = 2'b01;
   localparam logic [1:0] WIN_RIGHT = 2'b10;

   // Widest rope the helper can describe; callers cast down to their own width.
   localparam int unsigned MaxLights = 64;

   // Lights C..n-1 for a left win, 0..C for a right win, nothing otherwise.
   function automatic logic [MaxLights-1:0] half_mask(input int unsigned n,
                                                      input logic [1:0]  w);
      logic [MaxLights-1:0] m;
      logic [MaxLights-1:0] bit0;
      int unsigned          c;
      m    = '0;
      bit0 = {{(MaxLights-1){1'b0}}, 1'b1};
      c    = (n - 1) / 2;
      for (int unsigned i = 0; i < MaxLights; i++) begin
         if (i < n) begin
            if ((w == WIN_LEFT) && (i >= c)) m = m | (bit0 << i);
            if ((w == WIN_RIGHT) && (i <= c)) m = m | (bit0 << i);
         end
      end
      return m;
   endfunction

endpackage

// File: rtl/tug_timer.sv
// Loadable down-counter shared by the countdown and win-hold phases.
// done_o flags the last cycle of a loaded interval; the count rests at 0.
module tug_timer #(
   parameter int unsigned Width = 8
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic             load_i,
   input  logic [Width-1:0] load_val_i,
   output logic             done_o
);

   localparam logic [Width-1:0] One = {{(Width-1){1'b0}}, 1'b1};

   logic [Width-1:0] count_q, count_d;

   // Load wins over decrement; decrement stops at zero so the count never wraps.
   always_comb begin
      count_d = count_q;
      if (load_i) begin
         count_d = load_val_i;
      end else if (count_q != '0) begin
         count_d = count_q - 1'b1;
      end
   end

   // Count register.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) count_q <= '0;
      else         count_q <= count_d;
   end

   assign done_o = (count_q == One);

endmodule

// File: rtl/tug_referee.sv
// Tug-of-war referee: sequences rounds, moves the rope on press pulses and
// keeps scores. Optional macro FALSE_START_EN turns a lone press during the
// countdown into a round awarded to the opponent.
module tug_referee
   import tug_pkg::*;
#(
   parameter int unsigned NUM_LIGHTS   = 9,
   parameter int unsigned COUNT_CYCLES = 50000000,
   parameter int unsigned WIN_HOLD     = 100000000,
   parameter int unsigned SCORE_W      = 3
) (
   input  logic                  Clock,
   input  logic                  Reset_n,
   input  logic                  start,
   input  logic                  left_press,
   input  logic                  right_press,
   output logic [NUM_LIGHTS-1:0] lights,
   output logic [1:0]            winner,
   output logic [SCORE_W-1:0]    left_score,
   output logic [SCORE_W-1:0]    right_score,
   output logic                  busy
);

   localparam int unsigned Centre   = (NUM_LIGHTS - 1) / 2;
   localparam int unsigned PosW     = $clog2(NUM_LIGHTS);
   localparam int unsigned TimerMax = (COUNT_CYCLES > WIN_HOLD) ? COUNT_CYCLES : WIN_HOLD;
   localparam int unsigned TimerW   = $clog2(TimerMax + 1);

   localparam logic [PosW-1:0]       PosC      = PosW'(Centre);
   localparam logic [PosW-1:0]       PosTop    = PosW'(NUM_LIGHTS - 1);
   localparam logic [TimerW-1:0]     LoadCount = TimerW'(COUNT_CYCLES);
   localparam logic [TimerW-1:0]     LoadWin   = TimerW'(WIN_HOLD);
   localparam logic [SCORE_W-1:0]    ScoreMax  = '1;
   localparam logic [NUM_LIGHTS-1:0] OneLight  = {{(NUM_LIGHTS-1){1'b0}}, 1'b1};

   state_e                  state_q, state_d;
   logic [PosW-1:0]         pos_q, pos_d;
   logic [1:0]              winner_q, winner_d;
   logic [SCORE_W-1:0]      lscore_q, lscore_d;
   logic [SCORE_W-1:0]      rscore_q, rscore_d;
   logic [NUM_LIGHTS-1:0]   lights_q, lights_d;
   logic                    busy_q, busy_d;

   logic                    tmr_load;
   logic [TimerW-1:0]       tmr_val;
   logic                    tmr_done;
   logic                    award_left, award_right;

   tug_timer #(
      .Width (TimerW)
   ) u_timer (
      .clk_i      (Clock),
      .rst_ni     (Reset_n),
      .load_i     (tmr_load),
      .load_val_i (tmr_val),
      .done_o     (tmr_done)
   );

   // Round sequencing, rope movement and scoring.
   always_comb begin
      state_d     = state_q;
      pos_d       = pos_q;
      winner_d    = winner_q;
      lscore_d    = lscore_q;
      rscore_d    = rscore_q;
      tmr_load    = 1'b0;
      tmr_val     = LoadCount;
      award_left  = 1'b0;
      award_right = 1'b0;

      unique case (state_q)
         StIdle, StOver: begin
            if (start) begin
               lscore_d = '0;
               rscore_d = '0;
               pos_d    = PosC;
               winner_d = WIN_NONE;
               tmr_load = 1'b1;
               state_d  = StCountdown;
            end
         end
         StCountdown: begin
`ifdef FALSE_START_EN
            // A lone press hands the round to the other player; a tie cancels.
            if (left_press && !right_press) begin
               award_right = 1'b1;
            end else if (right_press && !left_press) begin
               award_left = 1'b1;
            end else if (tmr_done) begin
               state_d = StPlay;
            end
`else
            if (tmr_done) state_d = StPlay;
`endif
         end
         StPlay: begin
            // Winning needs a press while already parked on the player's edge.
            if (left_press && !right_press) begin
               if (pos_q == PosTop) award_left = 1'b1;
               else                 pos_d = pos_q + 1'b1;
            end else if (right_press && !left_press) begin
               if (pos_q == '0) award_right = 1'b1;
               else             pos_d = pos_q - 1'b1;
            end
         end
         StWin: begin
            if (tmr_done) begin
               if ((lscore_q == ScoreMax) || (rscore_q == ScoreMax)) begin
                  state_d = StOver;
               end else begin
                  winner_d = WIN_NONE;
                  pos_d    = PosC;
                  tmr_load = 1'b1;
                  state_d  = StCountdown;
               end
            end
         end
         default: state_d = StIdle;
      endcase

      if (award_left) begin
         if (lscore_q != ScoreMax) lscore_d = lscore_q + 1'b1;
         winner_d = WIN_LEFT;
         tmr_load = 1'b1;
         tmr_val  = LoadWin;
         state_d  = StWin;
      end else if (award_right) begin
         if (rscore_q != ScoreMax) rscore_d = rscore_q + 1'b1;
         winner_d = WIN_RIGHT;
         tmr_load = 1'b1;
         tmr_val  = LoadWin;
         state_d  = StWin;
      end
   end

   // Output decode from next state so the display registers track the state.
   always_comb begin
      lights_d = '0;
      busy_d   = (state_d == StCountdown) || (state_d == StPlay) || (state_d == StWin);
      unique case (state_d)
         StCountdown:  lights_d = OneLight << Centre;
         StPlay:       lights_d = OneLight << pos_d;
         StWin, StOver: lights_d = NUM_LIGHTS'(half_mask(NUM_LIGHTS, winner_d));
         default:      lights_d = '0;
      endcase
   end

   // State and registered outputs.
   always_ff @(posedge Clock or negedge Reset_n) begin
      if (!Reset_n) begin
         state_q  <= StIdle;
         pos_q    <= PosC;
         winner_q <= WIN_NONE;
         lscore_q <= '0;
         rscore_q <= '0;
         lights_q <= '0;
         busy_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         pos_q    <= pos_d;
         winner_q <= winner_d;
         lscore_q <= lscore_d;
         rscore_q <= rscore_d;
         lights_q <= lights_d;
         busy_q   <= busy_d;
      end
   end

   assign lights      = lights_q;
   assign winner      = winner_q;
   assign left_score  = lscore_q;
   assign right_score = rscore_q;
   assign busy        = busy_q;

endmodule

// File: tb/tb_tug_referee.sv
// Bench for tug_referee (5 lights, countdown 4, win hold 3, 2-bit scores).
// Honours FALSE_START_EN when the design is built with it.
module tb_tug_referee;

   localparam int NL   = 5;
   localparam int CC   = 4;
   localparam int WH   = 3;
   localparam int SW   = 2;
   localparam int C    = (NL - 1) / 2;
   localparam int SMAX = (1 << SW) - 1;

   localparam int MIdle = 0, MCd = 1, MPlay = 2, MWin = 3, MOver = 4;

   logic          Clock = 1'b0;
   logic          Reset_n = 1'b1;
   logic          start = 1'b0;
   logic          left_press = 1'b0;
   logic          right_press = 1'b0;
   logic [NL-1:0] lights;
   logic [1:0]    winner;
   logic [SW-1:0] left_score, right_score;
   logic          busy;

   int checks = 0;
   int errors = 0;

   // Reference model: phase plus cycles left in it, rope index, scores.
   int m_mode, m_left, m_pos, m_ls, m_rs, m_win;

   typedef struct {
      bit         s;
      bit         l;
      bit         r;
      logic [4:0] lt;
      logic [1:0] w;
      logic [1:0] ls;
      logic [1:0] rs;
      bit         b;
   } vec_t;

   vec_t vecs[20];

   tug_referee #(
      .NUM_LIGHTS   (NL),
      .COUNT_CYCLES (CC),
      .WIN_HOLD     (WH),
      .SCORE_W      (SW)
   ) dut (
      .Clock       (Clock),
      .Reset_n     (Reset_n),
      .start       (start),
      .left_press  (left_press),
      .right_press (right_press),
      .lights      (lights),
      .winner      (winner),
      .left_score  (left_score),
      .right_score (right_score),
      .busy        (busy)
   );

   always #5 Clock = ~Clock;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   function automatic void model_reset();
      m_mode = MIdle; m_left = 0; m_pos = C; m_ls = 0; m_rs = 0; m_win = 0;
   endfunction

   function automatic void award(input int w);
      if (w == 1) m_ls = (m_ls < SMAX) ? m_ls + 1 : SMAX;
      else        m_rs = (m_rs < SMAX) ? m_rs + 1 : SMAX;
      m_win  = w;
      m_mode = MWin;
      m_left = WH;
   endfunction

   function automatic void model_step(input bit s, input bit l, input bit r);
      bit fs;
      fs = 1'b0;
      case (m_mode)
         MIdle, MOver: if (s) begin
            m_ls = 0; m_rs = 0; m_pos = C; m_win = 0; m_mode = MCd; m_left = CC;
         end
         MCd: begin
`ifdef FALSE_START_EN
            if (l != r) begin
               award(l ? 2 : 1);
               fs = 1'b1;
            end
`endif
            if (!fs) begin
               m_left--;
               if (m_left == 0) m_mode = MPlay;
            end
         end
         MPlay: begin
            if (l && !r) begin
               if (m_pos == NL - 1) award(1);
               else m_pos++;
            end else if (r && !l) begin
               if (m_pos == 0) award(2);
               else m_pos--;
            end
         end
         MWin: begin
            m_left--;
            if (m_left == 0) begin
               if (m_ls == SMAX || m_rs == SMAX) m_mode = MOver;
               else begin
                  m_win = 0; m_pos = C; m_mode = MCd; m_left = CC;
               end
            end
         end
         default: m_mode = MIdle;
      endcase
   endfunction

   function automatic int m_lights();
      case (m_mode)
         MCd:   return 1 << C;
         MPlay: return 1 << m_pos;
         MWin, MOver: begin
            if (m_win == 1) return ((1 << NL) - 1) - ((1 << C) - 1);
            if (m_win == 2) return (1 << (C + 1)) - 1;
            return 0;
         end
         default: return 0;
      endcase
   endfunction

   task automatic check_model(input string tag);
      check({tag, ".lights"}, lights, m_lights());
      check({tag, ".winner"}, winner, m_win);
      check({tag, ".left_score"}, left_score, m_ls);
      check({tag, ".right_score"}, right_score, m_rs);
      check({tag, ".busy"}, busy, (m_mode == MCd || m_mode == MPlay || m_mode == MWin) ? 1 : 0);
   endtask

   // One clock: drive, step the model at the edge, check just after it.
   task automatic cycle(input bit s, input bit l, input bit r, input string tag);
      start = s; left_press = l; right_press = r;
      @(posedge Clock);
      model_step(s, l, r);
      #1;
      start = 1'b0; left_press = 1'b0; right_press = 1'b0;
      check_model(tag);
   endtask

   task automatic goto_play();
      for (int k = 0; k < 100 && m_mode != MPlay; k++)
         cycle(m_mode == MIdle || m_mode == MOver, 1'b0, 1'b0, "goto_play");
      if (m_mode != MPlay) begin
         checks++; errors++;
         $display("FAIL goto_play: timeout, got mode %0d, expected %0d", m_mode, MPlay);
      end
   endtask

   initial begin
      //          s  l  r  lights    w      ls     rs     busy
      vecs[0]  = '{1, 0, 0, 5'b00100, 2'd0, 2'd0, 2'd0, 1};
      vecs[1]  = '{0, 0, 0, 5'b00100, 2'd0, 2'd0, 2'd0, 1};
      vecs[2]  = '{0, 0, 0, 5'b00100, 2'd0, 2'd0, 2'd0, 1};
      vecs[3]  = '{0, 0, 0, 5'b00100, 2'd0, 2'd0, 2'd0, 1};
      vecs[4]  = '{0, 0, 0, 5'b00100, 2'd0, 2'd0, 2'd0, 1};
      vecs[5]  = '{0, 1, 0, 5'b01000, 2'd0, 2'd0, 2'd0, 1};
      vecs[6]  = '{0, 0, 0, 5'b01000, 2'd0, 2'd0, 2'd0, 1};
      vecs[7]  = '{0, 1, 0, 5'b10000, 2'd0, 2'd0, 2'd0, 1};
      vecs[8]  = '{0, 1, 1, 5'b10000, 2'd0, 2'd0, 2'd0, 1};
      vecs[9]  = '{0, 1, 0, 5'b11100, 2'd1, 2'd1, 2'd0, 1};
      vecs[10] = '{0, 0, 0, 5'b11100, 2'd1, 2'd1, 2'd0, 1};
      vecs[11] = '{0, 1, 1, 5'b11100, 2'd1, 2'd1, 2'd0, 1};
      vecs[12] = '{0, 0, 0, 5'b00100, 2'd0, 2'd1, 2'd0, 1};
      vecs[13] = '{0, 0, 0, 5'b00100, 2'd0, 2'd1, 2'd0, 1};
      vecs[14] = '{0, 0, 0, 5'b00100, 2'd0, 2'd1, 2'd0, 1};
      vecs[15] = '{0, 0, 0, 5'b00100, 2'd0, 2'd1, 2'd0, 1};
      vecs[16] = '{0, 0, 0, 5'b00100, 2'd0, 2'd1, 2'd0, 1};
      vecs[17] = '{0, 1, 1, 5'b00100, 2'd0, 2'd1, 2'd0, 1};
      vecs[18] = '{0, 0, 1, 5'b00010, 2'd0, 2'd1, 2'd0, 1};
      vecs[19] = '{1, 1, 0, 5'b00100, 2'd0, 2'd1, 2'd0, 1};

      // Reset: outputs must clear without a clock edge.
      model_reset();
      #2 Reset_n = 1'b0;
      #1;
      check_model("reset");
      repeat (2) @(posedge Clock);
      @(negedge Clock);
      Reset_n = 1'b1;

      // Directed table: countdown, left round win, cancel, right step, start ignored.
      for (int i = 0; i < 20; i++) begin
         string tag;
         tag = $sformatf("vec%0d", i);
         cycle(vecs[i].s, vecs[i].l, vecs[i].r, tag);
         check({tag, ".tbl_lights"}, lights, vecs[i].lt);
         check({tag, ".tbl_winner"}, winner, vecs[i].w);
         check({tag, ".tbl_lscore"}, left_score, vecs[i].ls);
         check({tag, ".tbl_rscore"}, right_score, vecs[i].rs);
         check({tag, ".tbl_busy"}, busy, vecs[i].b);
      end

      // Right player takes three rounds and ends the match.
      for (int k = 0; k < 300 && m_mode != MOver; k++)
         cycle(1'b0, 1'b0, m_mode == MPlay, "right_run");
      if (m_mode != MOver) begin
         checks++; errors++;
         $display("FAIL right_run: timeout, got mode %0d, expected %0d", m_mode, MOver);
      end
      check("over.right_score", right_score, 3);
      check("over.busy", busy, 0);
      check("over.winner", winner, 2'b10);
      check("over.lights", lights, 5'b00111);
      cycle(1'b0, 1'b1, 1'b1, "over_hold0");
      cycle(1'b0, 1'b1, 1'b0, "over_hold1");
      cycle(1'b1, 1'b0, 1'b0, "restart");
      check("restart.left_score", left_score, 0);
      check("restart.right_score", right_score, 0);
      check("restart.lights", lights, 5'b00100);
      check("restart.busy", busy, 1);

      // Right press in the second countdown cycle.
      cycle(1'b0, 1'b0, 1'b1, "fs_press");
`ifdef FALSE_START_EN
      check("fs.winner", winner, 2'b01);
      check("fs.left_score", left_score, 1);
`else
      check("fs.winner", winner, 2'b00);
      cycle(1'b0, 1'b0, 1'b0, "fs_cd3");
      cycle(1'b0, 1'b0, 1'b0, "fs_cd4");
      cycle(1'b0, 1'b1, 1'b0, "fs_last_cd");
      check("fs.last_cd_lights", lights, 5'b00100);
      cycle(1'b0, 1'b1, 1'b0, "fs_play");
      check("fs.play_lights", lights, 5'b01000);
`endif

      // Asynchronous reset mid-play with pos=3 and a nonzero score.
      for (int k = 0; k < 300 && m_ls == 0; k++)
         cycle(m_mode == MIdle || m_mode == MOver, m_mode == MPlay, 1'b0, "score_up");
      goto_play();
      cycle(1'b0, 1'b1, 1'b0, "pos3");
      check("pos3.lights", lights, 5'b01000);
      #2 Reset_n = 1'b0;
      #1;
      model_reset();
      check("async.lights", lights, 0);
      check("async.left_score", left_score, 0);
      check("async.right_score", right_score, 0);
      check("async.winner", winner, 0);
      check("async.busy", busy, 0);
      @(negedge Clock);
      Reset_n = 1'b1;
      cycle(1'b0, 1'b1, 1'b0, "idle_press");

      // Random stimulus against the model.
      for (int i = 0; i < 1500; i++) begin
         cycle($urandom_range(0, 19) == 0, $urandom_range(0, 2) == 0,
               $urandom_range(0, 2) == 0, "rand");
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
